// File: rtl/tff_arb_pkg.sv
// Shared constants and width rules for the T flip-flop bank arbiter.
package tff_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TOGGLE = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    // Index width, kept at least 1 so degenerate sizes still give a legal vector.
    function automatic int idx_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int cnt_w(input int settle_cyc);
        return (settle_cyc > 0) ? $clog2(settle_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/t_ff.sv
// Single T flip-flop storage cell; q clears asynchronously while rstn is low.
module t_ff (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next value: invert when t is set.
    always_comb begin
        q_d = q_q ^ t;
    end

    // Storage flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_REQ-1:0] win_oh
);

    logic [IDX_W-1:0] idx_s;
    logic             hit_s;

    // Walk from farthest to nearest so the candidate closest to ptr lands last.
    always_comb begin
        vld     = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s   = IDX_W'((int'(ptr) + k) % N_REQ);
            hit_s   = req[idx_s];
            vld     = vld | hit_s;
            win_idx = hit_s ? idx_s : win_idx;
            win_oh  = hit_s ? (N_REQ'(1) << idx_s) : win_oh;
        end
    end

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter that owns the t inputs of a shared T flip-flop bank,
// issuing one single-cycle toggle per grant followed by a settle window.
module tff_bank_arbiter
    import tff_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int WIDTH      = 8,
    parameter  int SETTLE_CYC = 2,
    localparam int IDX_W      = idx_w(N_REQ),
    localparam int CNT_W      = cnt_w(SETTLE_CYC)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] mask,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       t_vec,
    output logic [WIDTH-1:0]       q_vec,
    output logic                   busy,
    output logic [IDX_W-1:0]       gnt_id
);

    logic [1:0]       state_d, state_q;
    logic [IDX_W-1:0] ptr_d, ptr_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [N_REQ-1:0] gnt_d, gnt_q;
    logic [WIDTH-1:0] t_vec_d, t_vec_q;
    logic [IDX_W-1:0] gnt_id_d, gnt_id_q;
    logic             busy_d, busy_q;

    logic             pick_vld_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [N_REQ-1:0] pick_oh_s;
    logic [WIDTH-1:0] pick_mask_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .vld     (pick_vld_s),
        .win_idx (pick_idx_s),
        .win_oh  (pick_oh_s)
    );

    // Winner's mask via one-hot AND-OR so the slice select stays constant.
    always_comb begin
        pick_mask_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_mask_s = pick_mask_s | (mask[i*WIDTH +: WIDTH] & {WIDTH{pick_oh_s[i]}});
        end
    end

    // Arbitration FSM next-state and output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        t_vec_d  = t_vec_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_vld_s) begin
                    state_d  = TOGGLE;
                    gnt_d    = pick_oh_s;
                    t_vec_d  = pick_mask_s;
                    gnt_id_d = pick_idx_s;
                    ptr_d    = (int'(pick_idx_s) == N_REQ - 1) ? '0 : pick_idx_s + IDX_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            TOGGLE: begin
                gnt_d   = '0;
                t_vec_d = '0;
                if (SETTLE_CYC == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                t_vec_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            t_vec_q  <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            t_vec_q  <= t_vec_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
        end
    end

    // The bank toggles on the edge that closes the TOGGLE cycle, when t_vec is live.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bank
        t_ff u_cell (
            .clk  (clk),
            .rstn (rstn),
            .t    (t_vec_q[k]),
            .q    (q_vec[k])
        );
    end

    assign gnt    = gnt_q;
    assign t_vec  = t_vec_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed bench for tff_bank_arbiter with a per-cycle expected-value scoreboard.
module tb_tff_bank_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] t;
        logic [7:0] q;
        logic       busy;
        logic [1:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [31:0] mask = 32'h0;
    logic [3:0]  req2 = 4'h0;
    logic [31:0] mask2 = 32'h0;

    logic [3:0] gnt, gnt2;
    logic [7:0] t_vec, t_vec2, q_vec, q_vec2;
    logic       busy, busy2;
    logic [1:0] gnt_id, gnt_id2;

    tff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .SETTLE_CYC(2)) dut (
        .clk(clk), .rstn(rstn), .req(req), .mask(mask), .gnt(gnt),
        .t_vec(t_vec), .q_vec(q_vec), .busy(busy), .gnt_id(gnt_id)
    );

    tff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .SETTLE_CYC(0)) dut0 (
        .clk(clk), .rstn(rstn), .req(req2), .mask(mask2), .gnt(gnt2),
        .t_vec(t_vec2), .q_vec(q_vec2), .busy(busy2), .gnt_id(gnt_id2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    int         m_state;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_q, m_t;
    logic [3:0] m_gnt;
    logic [1:0] m_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_cnt = 0;
        m_q = 8'h00; m_t = 8'h00; m_gnt = 4'h0; m_id = 2'd0;
    endtask

    // Reference behaviour for SETTLE_CYC=2, one rising edge at a time.
    task automatic model_edge(input logic [3:0] r, input logic [31:0] m);
        int w;
        w = -1;
        case (m_state)
            0: begin
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                end
                if (w >= 0) begin
                    m_gnt = 4'b0001 << w;
                    m_t = m[w*8 +: 8];
                    m_id = 2'(w);
                    m_ptr = (w + 1) % 4;
                    m_state = 1;
                end
            end
            1: begin
                m_q = m_q ^ m_t;
                m_gnt = 4'h0;
                m_t = 8'h00;
                m_state = 2;
                m_cnt = 1;
            end
            default: begin
                if (m_cnt == 0) m_state = 0;
                else m_cnt = m_cnt - 1;
            end
        endcase
    endtask

    // Drive one cycle, predict it, then compare after the edge.
    task automatic cyc(input logic [3:0] r, input logic [31:0] m);
        exp_t e;
        req = r;
        mask = m;
        if (rstn) model_edge(r, m);
        else model_reset();
        e.gnt = m_gnt; e.t = m_t; e.q = m_q; e.busy = (m_state != 0); e.id = m_id;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("t_vec", 32'(t_vec), 32'(e.t));
            chk("q_vec", 32'(q_vec), 32'(e.q));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("gnt_id", 32'(gnt_id), 32'(e.id));
        end
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) cyc(4'h0, 32'h0);
        rstn = 1'b1;
    endtask

    // One full grant period (arbitrate, toggle, two settle cycles).
    task automatic grant_period(input logic [3:0] r, input logic [31:0] m,
                                input logic [1:0] ex_id, input logic [7:0] ex_q);
        cyc(r, m);
        chk("period_gnt_id", 32'(gnt_id), 32'(ex_id));
        chk("period_gnt_onehot", 32'(gnt), 32'(4'b0001 << ex_id));
        cyc(r, m);
        chk("period_q", 32'(q_vec), 32'(ex_q));
        cyc(r, m);
        cyc(r, m);
        chk("period_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] order[5];
        logic [7:0] qseq[5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        qseq  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
        model_reset();
        #1;

        // Reset held with all requests asserted.
        for (int i = 0; i < 4; i++) cyc(4'hF, 32'hFFFF_FFFF);
        chk("reset_q", 32'(q_vec), 32'h0);
        rstn = 1'b1;

        // Single requester, mask change during TOGGLE ignored, repeat grant.
        cyc(4'b0100, 32'h00A5_0000);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_t", 32'(t_vec), 32'hA5);
        cyc(4'b0100, 32'h00FF_0000);
        chk("single_q", 32'(q_vec), 32'hA5);
        cyc(4'b0100, 32'h00A5_0000);
        cyc(4'b0100, 32'h00A5_0000);
        chk("single_idle", 32'(busy), 32'd0);
        cyc(4'b0100, 32'h00A5_0000);
        chk("single_regrant", 32'(gnt), 32'h4);
        cyc(4'b0000, 32'h00A5_0000);
        chk("single_q_back", 32'(q_vec), 32'h00);
        cyc(4'b0000, 32'h0);
        cyc(4'b0000, 32'h0);

        // Pointer rotation after a grant to requester 2.
        grant_period(4'b1001, 32'h8000_0001, 2'd3, 8'h80);
        grant_period(4'b1001, 32'h8000_0001, 2'd0, 8'h81);

        // Fairness from a fresh pointer.
        do_reset(2);
        for (int i = 0; i < 5; i++) grant_period(4'hF, 32'h0804_0201, order[i], qseq[i]);

        // Winner with an all-zero mask.
        grant_period(4'b0010, 32'h0, 2'd1, 8'h0E);

        // Asynchronous reset while TOGGLE is in flight.
        cyc(4'b0001, 32'h0000_0033);
        chk("pre_reset_gnt", 32'(gnt), 32'h1);
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_t", 32'(t_vec), 32'h0);
        chk("async_q", 32'(q_vec), 32'h0);
        cyc(4'b0000, 32'h0);
        rstn = 1'b1;
        grant_period(4'b1001, 32'h4000_0002, 2'd0, 8'h02);

        // SETTLE_CYC=0 instance: grant every 2 cycles, busy only on TOGGLE.
        do_reset(2);
        req2 = 4'b0001;
        mask2 = 32'h0000_0001;
        for (int k = 0; k < 6; k++) begin
            cyc(4'h0, 32'h0);
            chk("s0_gnt", 32'(gnt2), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("s0_busy", 32'(busy2), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("s0_q", 32'(q_vec2), 32'(((k + 1) / 2) % 2));
            chk("s0_id", 32'(gnt_id2), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
